// File: rtl/oam_dma_engine.sv
// OAM DMA engine: a write to FF46 copies 160 bytes from XX00-XX9F into OAM FE00-FE9F.
// Optional macro OAM_DMA_CPU_LOCKOUT_EN drives cpu_blocked for non-HRAM CPU accesses while busy.
module oam_dma_engine #(
    parameter int          CLKS_PER_BYTE = 4,
    parameter int          START_DELAY   = 4,
    parameter logic [15:0] DMA_REG_ADDR  = 16'hFF46
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] A_cpu,
    input  logic [7:0]  Di_cpu,
    input  logic        rd_cpu_n,
    input  logic        wr_cpu_n,
    output logic        cs_dma,
    output logic [7:0]  Do_reg,
    output logic [15:0] A_dma,
    output logic        rd_dma_n,
    input  logic [7:0]  Di_dma,
    output logic [15:0] A_oam,
    output logic [7:0]  Do_oam,
    output logic        wr_oam_n,
    output logic        busy,
    output logic        done,
    output logic        cpu_blocked
);
    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    localparam logic [15:0] SD_LAST  = 16'(START_DELAY - 1);
    localparam logic [15:0] CPB_LAST = 16'(CLKS_PER_BYTE - 1);

    state_t      state;
    logic [15:0] phase;      // start-delay counter in START, byte phase in XFER
    logic [7:0]  idx;
    logic [7:0]  src_hi;
    logic [7:0]  byte_buf;
    logic        trigger;
    logic        rd_phase;
    logic        wr_phase;
    logic        unused_rd_cpu_n;

    assign unused_rd_cpu_n = rd_cpu_n;
    assign cs_dma  = (A_cpu == DMA_REG_ADDR);
    assign trigger = cs_dma && !wr_cpu_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            phase    <= '0;
            idx      <= '0;
            src_hi   <= '0;
            byte_buf <= '0;
            Do_reg   <= 8'hFF;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            // A new write always wins, even on the last transfer clock, so no done is emitted.
            if (trigger) begin
                Do_reg <= Di_cpu;
                src_hi <= (Di_cpu >= 8'hE0) ? Di_cpu - 8'h20 : Di_cpu;
                state  <= START;
                phase  <= '0;
                idx    <= '0;
                busy   <= 1'b1;
            end else begin
                case (state)
                    START: begin
                        if (phase == SD_LAST) begin
                            state <= XFER;
                            phase <= '0;
                        end else begin
                            phase <= phase + 16'd1;
                        end
                    end
                    XFER: begin
                        if (phase == 16'd0)
                            byte_buf <= Di_dma;
                        if (phase == CPB_LAST) begin
                            phase <= '0;
                            if (idx == 8'h9F) begin
                                state <= IDLE;
                                idx   <= '0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                idx <= idx + 8'd1;
                            end
                        end else begin
                            phase <= phase + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Bus outputs depend only on registered state; addresses rest at zero when not strobing.
    assign rd_phase = (state == XFER) && (phase == 16'd0);
    assign wr_phase = (state == XFER) && (phase == 16'd1);
    assign rd_dma_n = !rd_phase;
    assign wr_oam_n = !wr_phase;
    assign A_dma    = rd_phase ? {src_hi, idx} : 16'h0000;
    assign A_oam    = wr_phase ? (16'hFE00 + {8'h00, idx}) : 16'h0000;
    assign Do_oam   = wr_phase ? byte_buf : 8'h00;

`ifdef OAM_DMA_CPU_LOCKOUT_EN
    assign cpu_blocked = busy && !(A_cpu >= 16'hFF80 && A_cpu <= 16'hFFFE);
`else
    assign cpu_blocked = 1'b0;
`endif
endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine: default instance plus a fast (2 clk/byte, 1 clk delay) instance.
module tb_oam_dma_engine;
    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] A_cpu;
    logic [7:0]  Di_cpu;
    logic        rd_cpu_n, wr_cpu_n, wr2_n;

    logic        cs_dma, rd_dma_n, wr_oam_n, busy, done, cpu_blocked;
    logic [7:0]  Do_reg, Di_dma, Do_oam;
    logic [15:0] A_dma, A_oam;

    logic        cs_dma2, rd_dma_n2, wr_oam_n2, busy2, done2, cpu_blocked2;
    logic [7:0]  Do_reg2, Di_dma2, Do_oam2;
    logic [15:0] A_dma2, A_oam2;

    logic [7:0]  mem [65536];
    logic [7:0]  oam [160];
    logic [7:0]  oam2 [160];

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    assign Di_dma  = mem[A_dma];
    assign Di_dma2 = mem[A_dma2];

    oam_dma_engine dut (
        .clock(clock), .reset(reset), .A_cpu(A_cpu), .Di_cpu(Di_cpu),
        .rd_cpu_n(rd_cpu_n), .wr_cpu_n(wr_cpu_n), .cs_dma(cs_dma), .Do_reg(Do_reg),
        .A_dma(A_dma), .rd_dma_n(rd_dma_n), .Di_dma(Di_dma), .A_oam(A_oam),
        .Do_oam(Do_oam), .wr_oam_n(wr_oam_n), .busy(busy), .done(done),
        .cpu_blocked(cpu_blocked)
    );

    oam_dma_engine #(.CLKS_PER_BYTE(2), .START_DELAY(1)) dut2 (
        .clock(clock), .reset(reset), .A_cpu(A_cpu), .Di_cpu(Di_cpu),
        .rd_cpu_n(rd_cpu_n), .wr_cpu_n(wr2_n), .cs_dma(cs_dma2), .Do_reg(Do_reg2),
        .A_dma(A_dma2), .rd_dma_n(rd_dma_n2), .Di_dma(Di_dma2), .A_oam(A_oam2),
        .Do_oam(Do_oam2), .wr_oam_n(wr_oam_n2), .busy(busy2), .done(done2),
        .cpu_blocked(cpu_blocked2)
    );

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[15:8] ^ (a[7:0] * 8'd7) ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic trigger(input logic [7:0] d);
        @(negedge clock);
        A_cpu = 16'hFF46; Di_cpu = d; wr_cpu_n = 1'b0;
        @(negedge clock);
        wr_cpu_n = 1'b1; A_cpu = 16'h0000;
    endtask

    // Runs maxe clocks from the current negedge, capturing OAM writes and timing events.
    task automatic watch(input int maxe, output int first_rd, output logic [15:0] first_addr,
                         output int done_at, output int ndone, output int nbusy, output int nbad);
        first_rd = -1; first_addr = 16'h0; done_at = -1; ndone = 0; nbusy = 0; nbad = 0;
        for (int e = 0; e < maxe; e++) begin
            if (busy) nbusy++;
            if (!rd_dma_n && first_rd < 0) begin first_rd = e; first_addr = A_dma; end
            if (done) begin ndone++; if (done_at < 0) done_at = e; end
            if (!wr_oam_n) begin
                if (A_oam[15:8] == 8'hFE && A_oam[7:0] < 8'hA0) oam[A_oam[7:0]] = Do_oam;
                else nbad++;
            end
            @(negedge clock);
        end
    endtask

    function automatic int oam_diff(input logic [15:0] base, input int n);
        int d = 0;
        for (int i = 0; i < n; i++) if (oam[i] !== pat(base + 16'(i))) d++;
        return d;
    endfunction

    typedef struct {
        logic [7:0]  data;
        logic [15:0] base;
    } vec_t;

    initial begin
        vec_t vt [4];
        int first_rd, done_at, ndone, nbusy, nbad, nrd, nwr, nviol;
        logic [15:0] first_addr;

        vt[0] = '{8'hC1, 16'hC100};
        vt[1] = '{8'hE3, 16'hC300};
        vt[2] = '{8'hFE, 16'hDE00};
        vt[3] = '{8'h05, 16'h0500};

        for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
        reset = 1'b1; A_cpu = 16'h0; Di_cpu = 8'h0; rd_cpu_n = 1'b1; wr_cpu_n = 1'b1; wr2_n = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rd_dma_n", rd_dma_n, 1);
        chk("reset wr_oam_n", wr_oam_n, 1);
        chk("reset Do_reg", Do_reg, 8'hFF);
        chk("reset A_dma", A_dma, 0);
        chk("reset A_oam", A_oam, 0);
        chk("reset Do_oam", Do_oam, 0);
        A_cpu = 16'hFF46; #1 chk("cs_dma hit", cs_dma, 1);
        A_cpu = 16'hFF47; #1 chk("cs_dma miss", cs_dma, 0);
        A_cpu = 16'h0000;

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 160; i++) oam[i] = 8'h00;
            trigger(vt[v].data);
            chk("busy after trigger", busy, 1);
            watch(660, first_rd, first_addr, done_at, ndone, nbusy, nbad);
            chk("first read clock", first_rd, 4);
            chk("first read addr", first_addr, vt[v].base);
            chk("done clock", done_at, 644);
            chk("done count", ndone, 1);
            chk("busy clocks", nbusy, 644);
            chk("oam addr range", nbad, 0);
            chk("oam contents", oam_diff(vt[v].base, 160), 0);
            chk("Do_reg readback", Do_reg, vt[v].data);
        end

        // Restart at byte 80 with a new source.
        for (int i = 0; i < 160; i++) oam[i] = 8'h00;
        trigger(8'hC1);
        watch(4 + 80 * 4, first_rd, first_addr, done_at, ndone, nbusy, nbad);
        chk("restart no early done", ndone, 0);
        trigger(8'hD0);
        watch(660, first_rd, first_addr, done_at, ndone, nbusy, nbad);
        chk("restart first addr", first_addr, 16'hD000);
        chk("restart done clock", done_at, 644);
        chk("restart done count", ndone, 1);
        chk("restart oam", oam_diff(16'hD000, 160), 0);
        chk("restart Do_reg", Do_reg, 8'hD0);

        // Reset while byte 50 is being read.
        for (int i = 0; i < 160; i++) oam[i] = 8'h00;
        trigger(8'hC1);
        watch(4 + 50 * 4, first_rd, first_addr, done_at, ndone, nbusy, nbad);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset busy", busy, 0);
        chk("midreset rd_dma_n", rd_dma_n, 1);
        chk("midreset wr_oam_n", wr_oam_n, 1);
        chk("midreset Do_reg", Do_reg, 8'hFF);
        chk("midreset done", done, 0);
        reset = 1'b0;
        watch(700, first_rd, first_addr, done_at, ndone, nbusy, nbad);
        chk("midreset later done", ndone, 0);
        chk("midreset later busy", nbusy, 0);
        chk("midreset oam kept", oam_diff(16'hC100, 50), 0);
        nbad = 0;
        for (int i = 50; i < 160; i++) if (oam[i] !== 8'h00) nbad++;
        chk("midreset oam untouched", nbad, 0);

        // CPU lockout window.
        trigger(8'hC1);
        watch(10, first_rd, first_addr, done_at, ndone, nbusy, nbad);
`ifdef OAM_DMA_CPU_LOCKOUT_EN
        A_cpu = 16'hC000; #1 chk("lockout C000", cpu_blocked, 1);
        A_cpu = 16'hFF90; #1 chk("lockout FF90", cpu_blocked, 0);
        A_cpu = 16'hFFFF; #1 chk("lockout FFFF", cpu_blocked, 1);
`else
        A_cpu = 16'hC000; #1 chk("lockout C000", cpu_blocked, 0);
        A_cpu = 16'hFF90; #1 chk("lockout FF90", cpu_blocked, 0);
        A_cpu = 16'hFFFF; #1 chk("lockout FFFF", cpu_blocked, 0);
`endif
        chk("lockout idle instance", cpu_blocked2, 0);
        A_cpu = 16'h0000;
        watch(700, first_rd, first_addr, done_at, ndone, nbusy, nbad);
        A_cpu = 16'hC000; #1 chk("lockout after done", cpu_blocked, 0);
        A_cpu = 16'h0000;

        // Fast instance: reads and writes alternate every clock.
        for (int i = 0; i < 160; i++) oam2[i] = 8'h00;
        @(negedge clock);
        A_cpu = 16'hFF46; Di_cpu = 8'h42; wr2_n = 1'b0;
        #1 chk("fast cs_dma", cs_dma2, 1);
        @(negedge clock);
        wr2_n = 1'b1; A_cpu = 16'h0000;
        first_rd = -1; done_at = -1; ndone = 0; nbusy = 0; nrd = 0; nwr = 0; nviol = 0;
        for (int e = 0; e < 340; e++) begin
            if (busy2) nbusy++;
            if (!rd_dma_n2) begin nrd++; if (first_rd < 0) first_rd = e; end
            if (!wr_oam_n2) begin nwr++; oam2[A_oam2[7:0]] = Do_oam2; end
            if (e >= 1 && e <= 320 && (rd_dma_n2 == wr_oam_n2)) nviol++;
            if (done2) begin ndone++; if (done_at < 0) done_at = e; end
            @(negedge clock);
        end
        chk("fast busy clocks", nbusy, 321);
        chk("fast first read", first_rd, 1);
        chk("fast read count", nrd, 160);
        chk("fast write count", nwr, 160);
        chk("fast alternation", nviol, 0);
        chk("fast done clock", done_at, 321);
        chk("fast done count", ndone, 1);
        chk("fast Do_reg", Do_reg2, 8'h42);
        nbad = 0;
        for (int i = 0; i < 160; i++) if (oam2[i] !== pat(16'h4200 + 16'(i))) nbad++;
        chk("fast oam contents", nbad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
